// File: rtl/ascon_pack_fifo_pkg.sv
// Shared widths and word types for the Ascon block FIFO and its write-side packer.
package ascon_pack_fifo_pkg;

  localparam int BLOCK_WIDTH        = 64;
  localparam int DEFAULT_WORD_WIDTH = 32;

  typedef logic [31:0]  u32_t;
  typedef logic [63:0]  u64_t;
  typedef logic [127:0] u128_t;

endpackage

// File: rtl/ascon_pack_fifo_if.sv
// Write/read handshake bundle of the Ascon block FIFO; master drives words in, slave is the FIFO.
interface ascon_pack_fifo_if
  import ascon_pack_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = BLOCK_WIDTH,
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int DEPTH      = 4,
  parameter int LW         = $clog2(DEPTH + 1)
);

  logic                  flush_i;
  logic                  push_i;
  logic [WORD_WIDTH-1:0] data_i;
  logic                  last_i;
  logic                  pop_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  full_o;
  logic                  empty_o;
  logic                  almost_full_o;
  logic [LW-1:0]         level_o;
  logic                  pending_o;
  logic                  overflow_o;
  logic                  underflow_o;

  modport master (
    output flush_i, push_i, data_i, last_i, pop_i,
    input  data_o, full_o, empty_o, almost_full_o, level_o, pending_o,
           overflow_o, underflow_o
  );

  modport slave (
    input  flush_i, push_i, data_i, last_i, pop_i,
    output data_o, full_o, empty_o, almost_full_o, level_o, pending_o,
           overflow_o, underflow_o
  );

endinterface

// File: rtl/ascon_pack_fifo_word_packer.sv
// Gathers WORD_WIDTH words into one DATA_WIDTH entry, first word in the MSBs;
// a last word commits early with the unfilled low slots left at zero.
module ascon_word_packer
  import ascon_pack_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = BLOCK_WIDTH,
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic [WORD_WIDTH-1:0] data_i,
  input  logic                  last_i,
  input  logic                  full_i,
  output logic                  accept_o,
  output logic                  commit_o,
  output logic                  pending_o,
  output logic [DATA_WIDTH-1:0] entry_o
);

  localparam int RATIO = DATA_WIDTH / WORD_WIDTH;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [CW-1:0]         pack_cnt;
  logic [DATA_WIDTH-1:0] pack_reg;
  logic [DATA_WIDTH-1:0] slot_word;
  logic                  last_slot;

  always_comb begin
    slot_word = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (pack_cnt == CW'(k)) begin
        slot_word[DATA_WIDTH-1-k*WORD_WIDTH -: WORD_WIDTH] = data_i;
      end
    end
  end

  assign last_slot = (pack_cnt == CW'(RATIO - 1));
  assign accept_o  = push_i && !full_i && !clear_i;
  assign commit_o  = accept_o && (last_i || last_slot);
  // Storage captures the merged entry on the same edge the final word arrives.
  assign entry_o   = pack_reg | slot_word;
  assign pending_o = (pack_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_cnt <= '0;
      pack_reg <= '0;
    end else if (clear_i || commit_o) begin
      pack_cnt <= '0;
      pack_reg <= '0;
    end else if (accept_o) begin
      pack_cnt <= pack_cnt + 1'b1;
      pack_reg <= entry_o;
    end
  end

endmodule

// File: rtl/ascon_pack_fifo.sv
// Block FIFO for the Ascon AD/PT/CT queues: packed narrow writes, FWFT reads,
// level/almost-full status and sticky overflow/underflow flags cleared by flush.
module ascon_pack_fifo
  import ascon_pack_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = BLOCK_WIDTH,
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int DEPTH      = 4,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int LW         = $clog2(DEPTH + 1)
) (
  input logic             clk,
  input logic             rst_n,
  ascon_pack_fifo_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DATA_WIDTH % WORD_WIDTH != 0) begin : g_bad_ratio
    $fatal(1, "ascon_pack_fifo: DATA_WIDTH must be a multiple of WORD_WIDTH");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "ascon_pack_fifo: DEPTH must be at least 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $fatal(1, "ascon_pack_fifo: AF_THRESH must lie in 1..DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [LW-1:0]         level;
  logic                  overflow;
  logic                  underflow;

  logic                  full;
  logic                  empty;
  logic                  pop_acc;
  logic                  commit;
  logic                  accept;
  logic                  pending;
  logic [DATA_WIDTH-1:0] entry;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign pop_acc = bus.pop_i && !empty && !bus.flush_i;

  ascon_word_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (bus.flush_i),
    .push_i    (bus.push_i),
    .data_i    (bus.data_i),
    .last_i    (bus.last_i),
    .full_i    (full),
    .accept_o  (accept),
    .commit_o  (commit),
    .pending_o (pending),
    .entry_o   (entry)
  );

  always_ff @(posedge clk) begin
    if (commit) begin
      mem[wr_ptr] <= entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.flush_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (commit) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_acc) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({commit, pop_acc})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (bus.push_i && full) begin
        overflow <= 1'b1;
      end
      if (bus.pop_i && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  assign bus.data_o        = empty ? '0 : mem[rd_ptr];
  assign bus.full_o        = full;
  assign bus.empty_o       = empty;
  assign bus.almost_full_o = (level >= LW'(AF_THRESH));
  assign bus.level_o       = level;
  assign bus.pending_o     = pending;
  assign bus.overflow_o    = overflow;
  assign bus.underflow_o   = underflow;

endmodule
